// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs symbolic MIPS fields into 32-bit words,
// streams them into instruction memory, and appends a self-jump halt word.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              finish,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err_illegal
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    typedef enum logic {LOAD, DONE} state_t;

    state_t              state, stateNext;
    logic [ADDR_W-1:0]   wrPtr, wrPtrNext;
    logic [ADDR_W:0]     cnt, cntNext;
    logic                memWeNext;
    logic [ADDR_W-1:0]   memAddrNext;
    logic [31:0]         memWdataNext;
    logic                errNext;
    logic [31:0]         encWord;
    logic                encLegal;
    logic [ADDR_W-1:0]   slotAddr;
    logic [25:0]         haltTarget;

    assign slotAddr   = ADDR_W'(BASE_ADDR) + wrPtr;
    assign haltTarget = 26'(BASE_ADDR) + 26'(wrPtr);
    assign full       = (cnt == LAST_SLOT);
    assign count      = cnt;
    assign done       = (state == DONE);
    assign in_ready   = (state == LOAD) && !full && !finish;

    // Field packing for the supported opcode set; kinds 8..15 are flagged illegal.
    always_comb begin
        encWord  = '0;
        encLegal = 1'b1;
        case (in_kind)
            4'd0:    encWord = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            4'd1:    encWord = {6'b000010, in_target};
            4'd2:    encWord = {6'b000100, in_rs, in_rt, in_imm};
            4'd3:    encWord = {6'b000101, in_rs, in_rt, in_imm};
            4'd4:    encWord = {6'b001000, in_rs, in_rt, in_imm};
            4'd5:    encWord = {6'b001100, in_rs, in_rt, in_imm};
            4'd6:    encWord = {6'b100011, in_rs, in_rt, in_imm};
            4'd7:    encWord = {6'b101011, in_rs, in_rt, in_imm};
            default: encLegal = 1'b0;
        endcase
    end

    // Next-state and write-port logic; finish takes priority over a pending accept.
    always_comb begin
        stateNext    = state;
        wrPtrNext    = wrPtr;
        cntNext      = cnt;
        memWeNext    = 1'b0;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        errNext      = err_illegal;
        case (state)
            LOAD: begin
                if (finish) begin
                    memWeNext    = 1'b1;
                    memAddrNext  = slotAddr;
                    memWdataNext = {6'b000010, haltTarget};
                    wrPtrNext    = wrPtr + PTR_ONE;
                    cntNext      = cnt + CNT_ONE;
                    stateNext    = DONE;
                end else if (in_valid && in_ready) begin
                    if (encLegal) begin
                        memWeNext    = 1'b1;
                        memAddrNext  = slotAddr;
                        memWdataNext = encWord;
                        wrPtrNext    = wrPtr + PTR_ONE;
                        cntNext      = cnt + CNT_ONE;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            DONE: begin
                if (restart) begin
                    stateNext = LOAD;
                    wrPtrNext = '0;
                    cntNext   = '0;
                    errNext   = 1'b0;
                end
            end
            default: stateNext = LOAD;
        endcase
    end

    // State and registered outputs; async reset drops an in-flight strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            wrPtr       <= '0;
            cnt         <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_illegal <= 1'b0;
        end else begin
            state       <= stateNext;
            wrPtr       <= wrPtrNext;
            cnt         <= cntNext;
            mem_we      <= memWeNext;
            mem_addr    <= memAddrNext;
            mem_wdata   <= memWdataNext;
            err_illegal <= errNext;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench with a write scoreboard for instr_encoder_loader (ADDR_W=8 and ADDR_W=2).
module tb_instr_encoder_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    wr_t qa[$];
    wr_t qb[$];

    // main instance
    logic        inValid = 0, finish = 0, restart = 0;
    logic [3:0]  kind = 0;
    logic [4:0]  rs = 0, rt = 0, rd = 0, shamt = 0;
    logic [5:0]  funct = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic        inReady, memWe, full, done, errIll;
    logic [7:0]  memAddr;
    logic [31:0] memWdata;
    logic [8:0]  count;

    // small instance
    logic        bValid = 0, bFinish = 0;
    logic [15:0] bImm = 0;
    logic        bReady, bWe, bFull, bDone, bErr;
    logic [1:0]  bAddr;
    logic [31:0] bWdata;
    logic [2:0]  bCount;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_kind(kind),
        .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt), .in_funct(funct),
        .in_imm(imm), .in_target(target), .finish(finish), .restart(restart),
        .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .count(count),
        .full(full), .done(done), .err_illegal(errIll)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(bValid), .in_ready(bReady), .in_kind(4'd4),
        .in_rs(5'd0), .in_rt(5'd8), .in_rd(5'd0), .in_shamt(5'd0), .in_funct(6'd0),
        .in_imm(bImm), .in_target(26'd0), .finish(bFinish), .restart(1'b0),
        .mem_we(bWe), .mem_addr(bAddr), .mem_wdata(bWdata), .count(bCount),
        .full(bFull), .done(bDone), .err_illegal(bErr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one field set to the main instance for a single cycle.
    task automatic issue(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] im, input logic [25:0] tg);
        kind = k; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
    endtask

    task automatic pushA(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        qa.push_back(w);
    endtask

    task automatic pushB(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        qb.push_back(w);
    endtask

    // Scoreboard: every observed strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (memWe) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_write", {32'd0, memWdata}, 64'hDEAD);
            end else begin
                wr_t w;
                w = qa.pop_front();
                chk("a_addr", 64'(memAddr), 64'(w.addr));
                chk("a_data", 64'(memWdata), 64'(w.data));
            end
        end
        if (bWe) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write", {32'd0, bWdata}, 64'hDEAD);
            end else begin
                wr_t w;
                w = qb.pop_front();
                chk("b_addr", 64'(bAddr), 64'(w.addr));
                chk("b_data", 64'(bWdata), 64'(w.data));
            end
        end
    end

    initial begin
        // reset state
        #2;
        chk("rst_we", 64'(memWe), 64'd0);
        chk("rst_addr", 64'(memAddr), 64'd0);
        chk("rst_wdata", 64'(memWdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(errIll), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", 64'(inReady), 64'd1);

        // R-type
        pushA(0, 32'h00221820);
        issue(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
        chk("r_we", 64'(memWe), 64'd1);
        chk("r_count", 64'(count), 64'd1);
        step();
        chk("r_we_drop", 64'(memWe), 64'd0);

        // finish then restart
        finish = 1'b1;
        #1;
        chk("fin_ready", 64'(inReady), 64'd0);
        pushA(1, 32'h08000001);
        step();
        finish = 1'b0;
        chk("fin1_done", 64'(done), 64'd1);
        chk("fin1_count", 64'(count), 64'd2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs1_done", 64'(done), 64'd0);
        chk("rs1_count", 64'(count), 64'd0);

        // addi, sw back-to-back
        pushA(0, 32'h20080005);
        pushA(1, 32'hAFA8FFFC);
        kind = 4'd4; rs = 5'd0; rt = 5'd8; imm = 16'h0005; inValid = 1'b1;
        #1;
        chk("b2b_ready0", 64'(inReady), 64'd1);
        step();
        kind = 4'd7; rs = 5'd29; rt = 5'd8; imm = 16'hFFFC;
        chk("b2b_ready1", 64'(inReady), 64'd1);
        chk("b2b_we0", 64'(memWe), 64'd1);
        step();
        inValid = 1'b0;
        chk("b2b_we1", 64'(memWe), 64'd1);
        chk("b2b_count", 64'(count), 64'd2);

        // illegal kind, then a legal word
        issue(4'd9, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
        chk("ill_we", 64'(memWe), 64'd0);
        chk("ill_err", 64'(errIll), 64'd1);
        chk("ill_count", 64'(count), 64'd2);
        pushA(2, 32'h302200FF);
        issue(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0);
        chk("ill_err_sticky", 64'(errIll), 64'd1);
        chk("post_ill_count", 64'(count), 64'd3);

        // finish with valid held high in the same cycle
        kind = 4'd2; rs = 5'd0; rt = 5'd0; imm = 16'hFFFF;
        inValid = 1'b1; finish = 1'b1;
        #1;
        chk("fin_valid_ready", 64'(inReady), 64'd0);
        pushA(3, 32'h08000003);
        step();
        chk("fin_we", 64'(memWe), 64'd1);
        chk("fin_done", 64'(done), 64'd1);
        chk("fin_count", 64'(count), 64'd4);
        chk("fin_ready_done", 64'(inReady), 64'd0);
        step();
        inValid = 1'b0; finish = 1'b0;
        chk("done_no_write", 64'(memWe), 64'd0);
        chk("done_count_hold", 64'(count), 64'd4);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs2_err", 64'(errIll), 64'd0);
        chk("rs2_count", 64'(count), 64'd0);
        chk("rs2_ready", 64'(inReady), 64'd1);

        // remaining encodings
        pushA(0, 32'h08000010);
        issue(4'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
        pushA(1, 32'h1464FFFE);
        issue(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0);
        pushA(2, 32'h8FA90008);
        issue(4'd6, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0);
        pushA(3, 32'h1000FFFF);
        issue(4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);

        // async reset during a write strobe (that word is dropped, not expected)
        issue(4'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
        chk("ar_we_before", 64'(memWe), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_we", 64'(memWe), 64'd0);
        chk("ar_addr", 64'(memAddr), 64'd0);
        chk("ar_wdata", 64'(memWdata), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        step();
        rst = 1'b0;
        pushA(0, 32'h8FA90008);
        issue(4'd6, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0);
        chk("ar_next_count", 64'(count), 64'd1);
        step();

        // small instance: fill to the reserved slot, then halt
        for (int i = 1; i <= 3; i++) begin
            pushB(i - 1, 32'h20080000 | 32'(i));
            bImm = 16'(i); bValid = 1'b1;
            step();
        end
        chk("s_full", 64'(bFull), 64'd1);
        chk("s_ready", 64'(bReady), 64'd0);
        chk("s_count3", 64'(bCount), 64'd3);
        bImm = 16'h7; step();
        chk("s_full_nowrite", 64'(bCount), 64'd3);
        bValid = 1'b0; bFinish = 1'b1;
        pushB(3, 32'h08000003);
        step();
        bFinish = 1'b0;
        chk("s_halt_count", 64'(bCount), 64'd4);
        chk("s_done", 64'(bDone), 64'd1);
        step();
        step();

        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
